ex_mem_port_seq: RTL
====================

Name: ex_mem_port_seq

Overview:
N-lane EX-stage front end for the multi-issue pipeline. Owns the ID->EX stage register, hands the registered lane payloads to the per-lane execute units, and serialises their data-SRAM requests onto the single data-SRAM port in program order. Raises stallreq_for_ex while a bundle still holds more than one unserved memory op. Reorders lane results into program order for MEM. Buffers load data returned mid-bundle so MEM sees every load.

Parameters:
LANES, 2, issue lanes (>=1)
LANE_WD, 252, per-lane decoded payload width
RES_WD, 70, per-lane execute result width (to MEM)
STALL_WD, 6, stall bus width; bit 3 = EX hold, bit 4 = MEM hold, 1 = Stop
ROT_W, $clog2(LANES) (min 1), rotation field width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
flush  in  1  pipeline flush
stall  in  STALL_WD  stall bus
stallreq_for_ex  out  1  port-conflict stall request
id_to_ex_bus  in  ROT_W+LANES*LANE_WD+LANES  {rot, lane payloads (lane0 lowest), valid[LANES]}; rot = index of oldest lane
lane_bus  out  LANES*LANE_WD  registered payloads
lane_valid  out  LANES  registered valids
lane_mem_en / lane_mem_wen  in  LANES / LANES*4  per-lane request; wen==0 = load
lane_mem_addr / lane_mem_wdata  in  LANES*32 each
lane_result  in  LANES*RES_WD  per-lane results
data_sram_en / data_sram_wen  out  1 / 4
data_sram_addr / data_sram_wdata  out  32 each
data_sram_rdata  in  32  read data, one cycle after access
ex_to_mem_bus  out  LANES*(RES_WD+33)+LANES  program-order {ld_buf_valid, ld_buf_data, result} slots, plus last_mem_slot one-hot
perf_conflict_cycles  out  32  see Optional Feature

Behaviour:
- Stage register, priority order:
  - rst=0 -> clear;
  - flush -> clear;
  - stall[3]=1 && stall[4]=0 -> load bubble (all zero);
  - stall[3]=0 -> capture id_to_ex_bus;
  - otherwise hold.
- served[LANES], ld_pend (1b + lane idx), ld_buf_valid/data[LANES]: cleared on reset, flush, and on any register load (capture or bubble).
- pending = lane_valid & lane_mem_en & ~served.
- Grant is combinational: the first pending lane scanning rot, rot+1, ... mod LANES.
- data_sram_* driven from the granted lane; data_sram_en=0 and all SRAM outputs 0 when nothing is granted, flush=1, or rst=0.
- stallreq_for_ex = popcount(pending) > 1. Zero-latency for a single op. k ops take k cycles; k-1 of them stalled.
- Served marking: the granted lane is marked served at the clock edge only if the register does not load that edge. This prevents replay when downstream stalls hold the stage.
- Load buffering: a granted load with stallreq_for_ex=1 sets ld_pend. The next cycle, rdata is written into ld_buf[lane] and ld_buf_valid is set. The final (non-stalled) access is not buffered; MEM consumes its rdata directly.
- ex_to_mem_bus slot j is lane (rot+j) mod LANES. last_mem_slot marks the slot of the final grant (all-zero if none).
- rot >= LANES is illegal; behaviour is undefined, and an assertion fires in simulation.
- Reset values: every output 0.

Optional Feature:
EX_PERF_CNT_EN.
- Defined: perf_conflict_cycles counts cycles with stallreq_for_ex=1; saturates at 0xFFFFFFFF; cleared only by reset.
- Undefined: the port is tied to 0 and no counter flop exists.

Decomposition:
- Shared package ex_pkg: STALL_EX_BIT=3, STALL_MEM_BIT=4, STOP=1'b1, NOSTOP=1'b0, mem-request field offsets, program-order slot layout.
- Sub-module mem_grant_rr: rotating-priority first-one finder (pending, rot -> grant one-hot, count).

Test Plan:
1. Reset: rst=0 for 3 cycles with random inputs -> all outputs 0, lane_valid=0.
2. Single load, rot=0, lane0 addr 0x100 -> data_sram_en=1, addr 0x100, wen 0 in the same cycle; stallreq_for_ex=0; last_mem_slot=01.
3. Two stores, rot=0: lane0 0x10/0xAA, lane1 0x20/0xBB -> cycle1 addr 0x10, stallreq=1; cycle2 addr 0x20, stallreq=0; no third access despite a downstream stall[3]=1 hold.
4. Same bundle with rot=1 -> 0x20 first, then 0x10; slot0 = lane1 result.
5. Two loads, rot=0, rdata 0x1234 after the first -> slot0 ld_buf_valid=1, data 0x1234; slot1 ld_buf_valid=0; last_mem_slot=10.
6. Flush after the first of two stores -> data_sram_en=0 in the flush cycle; next cycle register, served and ld_buf are clear; with EX_PERF_CNT_EN the counter reads 1.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared stall-bus, memory-request and program-order slot layout definitions
package ex_pkg;

    localparam int   STALL_EX_BIT  = 3;
    localparam int   STALL_MEM_BIT = 4;
    localparam logic STOP          = 1'b1;
    localparam logic NOSTOP        = 1'b0;

    localparam int REQ_WEN_W  = 4;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int LD_DATA_W  = 32;

    // Slot layout, LSB first: result, buffered load data, buffered load valid.
    // ex_to_mem_bus places last_mem_slot in its low LANES bits, slot 0 directly above.
    function automatic int slot_w(input int res_wd);
        return res_wd + LD_DATA_W + 1;
    endfunction

    function automatic int slot_ld_data_off(input int res_wd);
        return res_wd;
    endfunction

    function automatic int slot_ld_valid_off(input int res_wd);
        return res_wd + LD_DATA_W;
    endfunction

    function automatic int slot_base(input int lanes, input int res_wd, input int j);
        return lanes + j * slot_w(res_wd);
    endfunction

endpackage

// File: rtl/mem_grant_rr.sv
// rtl/mem_grant_rr.sv - rotating-priority first-one finder over pending memory requests
module mem_grant_rr #(
    parameter int N     = 2,
    parameter int ROT_W = 1,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     pending_i,
    input  logic [ROT_W-1:0] rot_i,
    output logic [N-1:0]     grant_o,
    output logic [ROT_W-1:0] idx_o,
    output logic             any_o,
    output logic [CNT_W-1:0] count_o
);

    int               kk;
    logic [ROT_W-1:0] k;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        count_o = '0;
        found   = 1'b0;
        kk      = 0;
        k       = '0;
        for (int j = 0; j < N; j++) begin
            kk = int'(rot_i) + j;
            if (kk >= N) kk = kk - N;
            k = ROT_W'(kk);
            if (kk < N && pending_i[k] && !found) begin
                grant_o[k] = 1'b1;
                idx_o      = k;
                found      = 1'b1;
            end
        end
        any_o = found;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + CNT_W'(pending_i[i]);
        end
    end

endmodule

// File: rtl/ex_mem_port_seq.sv
// rtl/ex_mem_port_seq.sv - ID->EX register and in-order data-SRAM port sequencer for N lanes
// Optional: EX_PERF_CNT_EN adds a saturating port-conflict cycle counter.
module ex_mem_port_seq
    import ex_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int LANE_WD  = 252,
    parameter int RES_WD   = 70,
    parameter int STALL_WD = 6,
    parameter int ROT_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [STALL_WD-1:0]                    stall,
    output logic                                   stallreq_for_ex,
    input  logic [ROT_W+LANES*LANE_WD+LANES-1:0]   id_to_ex_bus,
    output logic [LANES*LANE_WD-1:0]               lane_bus,
    output logic [LANES-1:0]                       lane_valid,
    input  logic [LANES-1:0]                       lane_mem_en,
    input  logic [LANES*REQ_WEN_W-1:0]             lane_mem_wen,
    input  logic [LANES*REQ_ADDR_W-1:0]            lane_mem_addr,
    input  logic [LANES*REQ_DATA_W-1:0]            lane_mem_wdata,
    input  logic [LANES*RES_WD-1:0]                lane_result,
    output logic                                   data_sram_en,
    output logic [REQ_WEN_W-1:0]                   data_sram_wen,
    output logic [REQ_ADDR_W-1:0]                  data_sram_addr,
    output logic [REQ_DATA_W-1:0]                  data_sram_wdata,
    input  logic [LD_DATA_W-1:0]                   data_sram_rdata,
    output logic [LANES*(RES_WD+33)+LANES-1:0]     ex_to_mem_bus,
    output logic [31:0]                            perf_conflict_cycles
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int SW    = slot_w(RES_WD);

    logic [ROT_W-1:0]                  rot_q, rot_d;
    logic [LANES*LANE_WD-1:0]          lane_bus_q, lane_bus_d;
    logic [LANES-1:0]                  valid_q, valid_d;
    logic [LANES-1:0]                  served_q, served_d;
    logic                              ld_pend_q, ld_pend_d;
    logic [ROT_W-1:0]                  ld_pend_idx_q, ld_pend_idx_d;
    logic [LANES-1:0]                  ld_buf_valid_q, ld_buf_valid_d;
    logic [LANES-1:0][LD_DATA_W-1:0]   ld_buf_data_q, ld_buf_data_d;

    logic [LANES-1:0] pending, grant;
    logic [ROT_W-1:0] grant_idx;
    logic             grant_any;
    logic [CNT_W-1:0] pend_cnt;
    logic             capture, bubble, granted, granted_is_load;
    logic             unused_stall_bits;

    assign unused_stall_bits = ^stall;

    assign capture = (stall[STALL_EX_BIT] == NOSTOP);
    assign bubble  = (stall[STALL_EX_BIT] == STOP) && (stall[STALL_MEM_BIT] == NOSTOP);

    assign pending = valid_q & lane_mem_en & ~served_q & {LANES{rst}};

    mem_grant_rr #(.N(LANES), .ROT_W(ROT_W), .CNT_W(CNT_W)) u_grant (
        .pending_i (pending),
        .rot_i     (rot_q),
        .grant_o   (grant),
        .idx_o     (grant_idx),
        .any_o     (grant_any),
        .count_o   (pend_cnt)
    );

    assign stallreq_for_ex = (pend_cnt > CNT_W'(1));
    assign granted         = grant_any && !flush;

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        granted_is_load = 1'b0;
        if (granted) begin
            for (int i = 0; i < LANES; i++) begin
                if (grant[i]) begin
                    data_sram_en    = 1'b1;
                    data_sram_wen   = lane_mem_wen[i*REQ_WEN_W +: REQ_WEN_W];
                    data_sram_addr  = lane_mem_addr[i*REQ_ADDR_W +: REQ_ADDR_W];
                    data_sram_wdata = lane_mem_wdata[i*REQ_DATA_W +: REQ_DATA_W];
                    granted_is_load = (lane_mem_wen[i*REQ_WEN_W +: REQ_WEN_W] == '0);
                end
            end
        end
    end

    always_comb begin
        rot_d          = rot_q;
        lane_bus_d     = lane_bus_q;
        valid_d        = valid_q;
        served_d       = served_q;
        ld_pend_d      = ld_pend_q;
        ld_pend_idx_d  = ld_pend_idx_q;
        ld_buf_valid_d = ld_buf_valid_q;
        ld_buf_data_d  = ld_buf_data_q;
        if (flush || capture || bubble) begin
            rot_d          = '0;
            lane_bus_d     = '0;
            valid_d        = '0;
            served_d       = '0;
            ld_pend_d      = 1'b0;
            ld_pend_idx_d  = '0;
            ld_buf_valid_d = '0;
            ld_buf_data_d  = '0;
            if (!flush && capture) begin
                rot_d      = id_to_ex_bus[LANES*LANE_WD+LANES +: ROT_W];
                lane_bus_d = id_to_ex_bus[LANES +: LANES*LANE_WD];
                valid_d    = id_to_ex_bus[LANES-1:0];
            end
        end else begin
            // Held stage: remember what was served so a downstream hold never replays an access.
            if (granted) served_d = served_q | grant;
            ld_pend_d     = granted && granted_is_load && stallreq_for_ex;
            ld_pend_idx_d = grant_idx;
            if (ld_pend_q) begin
                ld_buf_valid_d[ld_pend_idx_q] = 1'b1;
                ld_buf_data_d[ld_pend_idx_q]  = data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rot_q          <= '0;
            lane_bus_q     <= '0;
            valid_q        <= '0;
            served_q       <= '0;
            ld_pend_q      <= 1'b0;
            ld_pend_idx_q  <= '0;
            ld_buf_valid_q <= '0;
            ld_buf_data_q  <= '0;
        end else begin
            rot_q          <= rot_d;
            lane_bus_q     <= lane_bus_d;
            valid_q        <= valid_d;
            served_q       <= served_d;
            ld_pend_q      <= ld_pend_d;
            ld_pend_idx_q  <= ld_pend_idx_d;
            ld_buf_valid_q <= ld_buf_valid_d;
            ld_buf_data_q  <= ld_buf_data_d;
        end
    end

    assign lane_bus   = lane_bus_q;
    assign lane_valid = valid_q;

    int               skk;
    logic [ROT_W-1:0] sk;

    always_comb begin
        ex_to_mem_bus = '0;
        skk           = 0;
        sk            = '0;
        if (rst) begin
            for (int j = 0; j < LANES; j++) begin
                skk = int'(rot_q) + j;
                if (skk >= LANES) skk = skk - LANES;
                sk = ROT_W'(skk);
                if (skk < LANES) begin
                    ex_to_mem_bus[slot_base(LANES, RES_WD, j) +: RES_WD] =
                        lane_result[sk*RES_WD +: RES_WD];
                    ex_to_mem_bus[slot_base(LANES, RES_WD, j) + slot_ld_data_off(RES_WD) +: LD_DATA_W] =
                        ld_buf_data_q[sk];
                    ex_to_mem_bus[slot_base(LANES, RES_WD, j) + slot_ld_valid_off(RES_WD)] =
                        ld_buf_valid_q[sk];
                end
            end
            // Last memory op in program order; later slots overwrite earlier ones.
            for (int j = 0; j < LANES; j++) begin
                skk = int'(rot_q) + j;
                if (skk >= LANES) skk = skk - LANES;
                sk = ROT_W'(skk);
                if (skk < LANES && valid_q[sk] && lane_mem_en[sk]) begin
                    ex_to_mem_bus[LANES-1:0] = '0;
                    ex_to_mem_bus[j]         = 1'b1;
                end
            end
        end
    end

`ifdef EX_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (stallreq_for_ex && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) perf_q <= '0;
        else      perf_q <= perf_d;
    end

    assign perf_conflict_cycles = perf_q;
`else
    assign perf_conflict_cycles = '0;
`endif

    assert property (@(posedge clk) disable iff (!rst)
        (valid_q == '0) || (32'(rot_q) < LANES));

    logic unused_sw;
    assign unused_sw = (SW == 0);

endmodule
